// File: rtl/hid_transmitter.sv
// PS/2 host-to-device transmitter: request-to-send, LSB-first shift on device clock
// falling edges, odd parity, stop bit and ACK check, with an inter-edge watchdog.
module hid_transmitter #(
  parameter int INHIBIT_CYC = 12000,
  parameter int SETUP_CYC   = 2000,
  parameter int TIMEOUT_CYC = 1500000
) (
  input  logic       dspclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       hid_clk,
  input  logic       hid_dat,
  output logic       hid_clk_oe,
  output logic       hid_dat_oe,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_ACK, S_WAIT_IDLE
  } state_t;

  localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYC - 1);
  localparam logic [20:0] SETUP_LAST   = 21'(SETUP_CYC - 1);
  localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYC - 1);

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t      state_r, state_s;
  logic [20:0] cnt_r, cnt_s;
  logic [3:0]  idx_r, idx_s;
  logic [9:0]  frame_r, frame_s;
  logic        clk_meta_r, clk_sync_r, clk_prev_r;
  logic        dat_meta_r, dat_sync_r;
  logic        clk_oe_r, clk_oe_s, dat_oe_r, dat_oe_s;
  logic        done_r, done_s;
  logic        ack_err_r, ack_err_s, timeout_err_r, timeout_err_s;
  logic        busy_r, tx_ready_r;
  logic        fall_s, clk_move_s, wd_active_s;

  assign fall_s      = clk_prev_r & ~clk_sync_r;
  // The rise seen right after SEND entry is our own clock release, not a device edge.
  assign clk_move_s  = (clk_sync_r ^ clk_prev_r) &
                       ~((state_r == S_SEND) && (idx_r == 4'd0) && clk_sync_r);
  assign wd_active_s = (state_r == S_SEND) || (state_r == S_WAIT_ACK) ||
                       (state_r == S_WAIT_IDLE);

  // Pad synchronisers and edge-history register
  always_ff @(posedge dspclk or posedge reset) begin
    if (reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= hid_clk;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= hid_dat;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r + 21'd1;
    idx_s         = idx_r;
    frame_s       = frame_r;
    clk_oe_s      = 1'b0;
    dat_oe_s      = dat_oe_r;
    done_s        = 1'b0;
    ack_err_s     = ack_err_r;
    timeout_err_s = timeout_err_r;

    if (wd_active_s && !clk_move_s && (cnt_r == TIMEOUT_LAST)) begin
      state_s       = S_IDLE;
      cnt_s         = 21'd0;
      dat_oe_s      = 1'b0;
      done_s        = 1'b1;
      timeout_err_s = 1'b1;
    end else begin
      if (wd_active_s && clk_move_s) begin
        cnt_s = 21'd0;
      end else begin
        cnt_s = cnt_r + 21'd1;
      end
      case (state_r)
        S_IDLE: begin
          cnt_s    = 21'd0;
          dat_oe_s = 1'b0;
          if (tx_valid) begin
            state_s       = S_INHIBIT;
            frame_s       = {1'b1, odd_parity(tx_data), tx_data};
            clk_oe_s      = 1'b1;
            ack_err_s     = 1'b0;
            timeout_err_s = 1'b0;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_INHIBIT: begin
          clk_oe_s = 1'b1;
          dat_oe_s = 1'b0;
          if (cnt_r == INHIBIT_LAST) begin
            state_s  = S_RTS;
            cnt_s    = 21'd0;
            dat_oe_s = 1'b1;
          end else begin
            state_s = S_INHIBIT;
          end
        end
        S_RTS: begin
          clk_oe_s = 1'b1;
          dat_oe_s = 1'b1;
          if (cnt_r == SETUP_LAST) begin
            state_s  = S_SEND;
            cnt_s    = 21'd0;
            idx_s    = 4'd0;
            clk_oe_s = 1'b0;
          end else begin
            state_s = S_RTS;
          end
        end
        S_SEND: begin
          if (fall_s) begin
            dat_oe_s = ~frame_r[idx_r];
            idx_s    = idx_r + 4'd1;
            if (idx_r == 4'd9) begin
              state_s = S_WAIT_ACK;
            end else begin
              state_s = S_SEND;
            end
          end else begin
            state_s = S_SEND;
          end
        end
        S_WAIT_ACK: begin
          dat_oe_s = 1'b0;
          if (fall_s) begin
            ack_err_s = dat_sync_r;
            state_s   = S_WAIT_IDLE;
          end else begin
            state_s = S_WAIT_ACK;
          end
        end
        S_WAIT_IDLE: begin
          dat_oe_s = 1'b0;
          if (clk_sync_r && dat_sync_r) begin
            done_s  = 1'b1;
            state_s = S_IDLE;
          end else begin
            state_s = S_WAIT_IDLE;
          end
        end
        default: begin
          state_s  = S_IDLE;
          cnt_s    = 21'd0;
          dat_oe_s = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset releases both pads at once
  always_ff @(posedge dspclk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      cnt_r         <= 21'd0;
      idx_r         <= 4'd0;
      frame_r       <= 10'd0;
      clk_oe_r      <= 1'b0;
      dat_oe_r      <= 1'b0;
      done_r        <= 1'b0;
      ack_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      busy_r        <= 1'b0;
      tx_ready_r    <= 1'b1;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      frame_r       <= frame_s;
      clk_oe_r      <= clk_oe_s;
      dat_oe_r      <= dat_oe_s;
      done_r        <= done_s;
      ack_err_r     <= ack_err_s;
      timeout_err_r <= timeout_err_s;
      busy_r        <= (state_s != S_IDLE);
      tx_ready_r    <= (state_s == S_IDLE);
    end
  end

  assign hid_clk_oe  = clk_oe_r;
  assign hid_dat_oe  = dat_oe_r;
  assign done        = done_r;
  assign ack_err     = ack_err_r;
  assign timeout_err = timeout_err_r;
  assign busy        = busy_r;
  assign tx_ready    = tx_ready_r;

endmodule

// File: tb/tb_hid_transmitter.sv
// Directed bench for hid_transmitter: a PS/2 device model on open-drain pads,
// shrunken timing parameters, and hand-computed frame/flag expectations.
module tb_hid_transmitter;
  localparam int INH  = 20;
  localparam int SET  = 10;
  localparam int TO   = 200;
  localparam int HALF = 15;

  logic       dspclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, hid_clk, hid_dat, hid_clk_oe, hid_dat_oe;
  logic       done, ack_err, timeout_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  assign hid_clk = ~(hid_clk_oe | dev_clk_low);
  assign hid_dat = ~(hid_dat_oe | dev_dat_low);

  always #5 dspclk = ~dspclk;

  hid_transmitter #(.INHIBIT_CYC(INH), .SETUP_CYC(SET), .TIMEOUT_CYC(TO)) dut (
    .dspclk(dspclk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .hid_clk(hid_clk), .hid_dat(hid_dat),
    .hid_clk_oe(hid_clk_oe), .hid_dat_oe(hid_dat_oe), .done(done),
    .ack_err(ack_err), .timeout_err(timeout_err)
  );

  // Waveform monitor: clk-only and both-low windows, clk_oe rising count
  int   inh_cnt = 0, both_cnt = 0, oe_rises = 0;
  logic prev_clk_oe = 1'b0;
  always @(negedge dspclk) begin
    if (hid_clk_oe && !hid_dat_oe) inh_cnt <= inh_cnt + 1;
    if (hid_clk_oe && hid_dat_oe) both_cnt <= both_cnt + 1;
    if (hid_clk_oe && !prev_clk_oe) oe_rises <= oe_rises + 1;
    prev_clk_oe <= hid_clk_oe;
  end

  task automatic request(input logic [7:0] d, input bit hold);
    @(negedge dspclk);
    tx_data  = d;
    tx_valid = 1'b1;
    if (!hold) begin
      @(negedge dspclk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_release(output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge dspclk);
      if (seen && !hid_clk_oe) begin
        ok = 1'b1;
        break;
      end
      if (hid_clk_oe) seen = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge dspclk);
      cycles++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Device clocking: sample start at release, then n clocks sampled before each rise
  task automatic dev_clocks(input int n, output logic [10:0] bits);
    bits = 11'bx;
    repeat (HALF) @(negedge dspclk);
    bits[0] = hid_dat;
    for (int k = 1; k <= n; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge dspclk);
      bits[k] = hid_dat;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge dspclk);
    end
  endtask

  task automatic dev_ack(input bit ack);
    if (ack) dev_dat_low = 1'b1;
    repeat (5) @(negedge dspclk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge dspclk);
    dev_clk_low = 1'b0;
    if (ack) begin
      repeat (5) @(negedge dspclk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge dspclk);
    n_cmp += 7;
    if (hid_clk_oe !== 1'b0) begin n_err++; $display("FAIL rst_clk_oe got %b want 0", hid_clk_oe); end
    if (hid_dat_oe !== 1'b0) begin n_err++; $display("FAIL rst_dat_oe got %b want 0", hid_dat_oe); end
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    if (ack_err !== 1'b0) begin n_err++; $display("FAIL rst_ack_err got %b want 0", ack_err); end
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
    reset = 1'b0;
  endtask

  task automatic test_ed_frame;
    bit ok_r, ok_d;
    int cyc;
    logic [10:0] bits;
    request(8'hED, 1'b0);
    wait_release(ok_r);
    dev_clocks(10, bits);
    dev_ack(1'b1);
    wait_done(ok_d, cyc);
    n_cmp += 7;
    if (!(ok_r && ok_d)) begin n_err++; $display("FAIL ed_handshake got rel=%b done=%b want 1 1", ok_r, ok_d); end
    if (bits !== 11'b11111011010) begin n_err++; $display("FAIL ed_bits got %b want 11111011010", bits); end
    if (ack_err !== 1'b0) begin n_err++; $display("FAIL ed_ack_err got %b want 0", ack_err); end
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL ed_timeout_err got %b want 0", timeout_err); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL ed_busy_at_done got %b want 0", busy); end
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL ed_ready_at_done got %b want 1", tx_ready); end
    @(negedge dspclk);
    if (done !== 1'b0) begin n_err++; $display("FAIL ed_done_width got %b want 0", done); end
  endtask

  task automatic test_parity;
    logic [7:0] dat_t [4] = '{8'h00, 8'hFF, 8'h01, 8'hF4};
    logic       par_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit ok_r, ok_d;
    int cyc;
    logic [10:0] bits;
    for (int i = 0; i < 4; i++) begin
      request(dat_t[i], 1'b0);
      wait_release(ok_r);
      dev_clocks(10, bits);
      dev_ack(1'b1);
      wait_done(ok_d, cyc);
      n_cmp += 2;
      if (bits[9] !== par_t[i]) begin n_err++; $display("FAIL parity_%02h got %b want %b", dat_t[i], bits[9], par_t[i]); end
      if (!(ok_r && ok_d) || ack_err !== 1'b0) begin
        n_err++; $display("FAIL parity_xfer_%02h got rel=%b done=%b ack_err=%b want 1 1 0", dat_t[i], ok_r, ok_d, ack_err);
      end
    end
  endtask

  task automatic test_no_ack;
    bit ok_r, ok_d;
    int cyc;
    logic [10:0] bits;
    request(8'h55, 1'b0);
    wait_release(ok_r);
    dev_clocks(10, bits);
    dev_ack(1'b0);
    wait_done(ok_d, cyc);
    n_cmp += 3;
    if (!(ok_r && ok_d)) begin n_err++; $display("FAIL noack_handshake got rel=%b done=%b want 1 1", ok_r, ok_d); end
    if (ack_err !== 1'b1 || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL noack_flags got ack=%b to=%b want 1 0", ack_err, timeout_err);
    end
    @(negedge dspclk);
    if (hid_clk_oe !== 1'b0 || hid_dat_oe !== 1'b0) begin
      n_err++; $display("FAIL noack_release got clk_oe=%b dat_oe=%b want 0 0", hid_clk_oe, hid_dat_oe);
    end
  endtask

  task automatic test_timeout;
    bit ok_r, ok_d;
    int cyc;
    request(8'hA5, 1'b0);
    wait_release(ok_r);
    wait_done(ok_d, cyc);
    n_cmp += 4;
    if (!(ok_r && ok_d)) begin n_err++; $display("FAIL to_handshake got rel=%b done=%b want 1 1", ok_r, ok_d); end
    if (cyc != TO) begin n_err++; $display("FAIL to_latency got %0d want %0d", cyc, TO); end
    if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_flag got %b want 1", timeout_err); end
    if (hid_clk_oe !== 1'b0 || hid_dat_oe !== 1'b0) begin
      n_err++; $display("FAIL to_release got clk_oe=%b dat_oe=%b want 0 0", hid_clk_oe, hid_dat_oe);
    end
  endtask

  task automatic test_windows_hold;
    bit ok_r, ok_d;
    int cyc, inh0, both0, rise0;
    logic [10:0] bits;
    inh0 = inh_cnt; both0 = both_cnt; rise0 = oe_rises;
    request(8'h3C, 1'b1);
    wait_release(ok_r);
    dev_clocks(10, bits);
    dev_ack(1'b1);
    wait_done(ok_d, cyc);
    tx_valid = 1'b0;
    repeat (INH + 5) @(negedge dspclk);
    n_cmp += 4;
    if (!(ok_r && ok_d)) begin n_err++; $display("FAIL win_handshake got rel=%b done=%b want 1 1", ok_r, ok_d); end
    if (inh_cnt - inh0 != INH) begin n_err++; $display("FAIL win_inhibit got %0d want %0d", inh_cnt - inh0, INH); end
    if (both_cnt - both0 != SET) begin n_err++; $display("FAIL win_setup got %0d want %0d", both_cnt - both0, SET); end
    if (oe_rises - rise0 != 1) begin n_err++; $display("FAIL hold_accepts got %0d want 1", oe_rises - rise0); end
  endtask

  task automatic test_reset_mid;
    bit ok_r, ok_d;
    int cyc;
    logic [10:0] bits;
    request(8'h00, 1'b0);
    wait_release(ok_r);
    dev_clocks(5, bits);
    repeat (3) @(negedge dspclk);
    n_cmp += 2;
    if (!ok_r || hid_dat_oe !== 1'b1) begin n_err++; $display("FAIL mid_bit4_drive got rel=%b dat_oe=%b want 1 1", ok_r, hid_dat_oe); end
    #2 reset = 1'b1;
    #1;
    if (hid_clk_oe !== 1'b0 || hid_dat_oe !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_async_release got clk_oe=%b dat_oe=%b busy=%b want 0 0 0", hid_clk_oe, hid_dat_oe, busy);
    end
    @(negedge dspclk);
    reset = 1'b0;
    request(8'hFF, 1'b0);
    wait_release(ok_r);
    dev_clocks(10, bits);
    dev_ack(1'b1);
    wait_done(ok_d, cyc);
    n_cmp += 2;
    if (!(ok_r && ok_d) || ack_err !== 1'b0 || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL post_rst_xfer got rel=%b done=%b ack=%b to=%b want 1 1 0 0", ok_r, ok_d, ack_err, timeout_err);
    end
    if (bits !== 11'b11111111110) begin n_err++; $display("FAIL post_rst_bits got %b want 11111111110", bits); end
  endtask

  initial begin
    test_reset;
    test_ed_frame;
    test_parity;
    test_no_ack;
    test_timeout;
    test_windows_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
